// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding slot per functional unit, round-robin grant, registered broadcast.
// Latency: result captured at posedge k is broadcast no earlier than after posedge k+1; one broadcast per cycle.
// Backpressure: result_ready_o drops only while a source's slot is full and not granted this cycle.

package types_pkg;
    localparam int FU_CNT = 4;

    typedef enum logic [1:0] {
        FU_ALU = 2'd0,
        FU_MUL = 2'd1,
        FU_DIV = 2'd2,
        FU_LSU = 2'd3
    } e_functional_unit;
endpackage

module cdb_arbiter
    import types_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int N_SRC      = FU_CNT
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [N_SRC-1:0]                    result_valid_i,
    input  logic [N_SRC-1:0][DATA_WIDTH-1:0]    result_data_i,
    output logic [N_SRC-1:0]                    result_ready_o,
    input  logic                                flush_i,
    output logic                                bcast_en_o,
    output logic [DATA_WIDTH-1:0]               bcast_data_o,
    output e_functional_unit                    bcast_rs_o,
    output logic [$clog2(N_SRC+1)-1:0]          pending_cnt_o
);
    localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int CNT_W = $clog2(N_SRC + 1);
    localparam int FU_W  = $bits(e_functional_unit);

    logic [N_SRC-1:0]                 slot_valid;
    logic [N_SRC-1:0][DATA_WIDTH-1:0] slot_data;
    logic [IDX_W-1:0]                 rr_ptr;

    logic                             grant_vld;
    logic [IDX_W-1:0]                 grant_idx;
    logic [N_SRC-1:0]                 grant_oh;
    logic [N_SRC-1:0]                 xfer;
    logic [IDX_W-1:0]                 next_ptr;

    // Walk candidates from farthest to nearest so the nearest occupied slot to rr_ptr wins.
    always_comb begin : rr_search
        int               idx;
        logic [IDX_W-1:0] cand;
        idx       = 0;
        cand      = '0;
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N_SRC) begin
                idx = idx - N_SRC;
            end
            cand = IDX_W'(idx);
            if (slot_valid[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
        if (flush_i) begin
            grant_vld = 1'b0;
        end
    end

    always_comb begin : grant_decode
        grant_oh = '0;
        for (int i = 0; i < N_SRC; i++) begin
            grant_oh[i] = grant_vld && (grant_idx == IDX_W'(i));
        end
    end

    assign result_ready_o = ~slot_valid | grant_oh | {N_SRC{flush_i}};
    assign xfer           = result_valid_i & result_ready_o;
    assign next_ptr       = (grant_idx == IDX_W'(N_SRC - 1)) ? '0 : grant_idx + IDX_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_valid <= '0;
            slot_data  <= '0;
        end else if (flush_i) begin
            slot_valid <= '0;
        end else begin
            // A granted slot that is refilled in the same cycle stays occupied with the new value.
            for (int i = 0; i < N_SRC; i++) begin
                if (xfer[i]) begin
                    slot_valid[i] <= 1'b1;
                    slot_data[i]  <= result_data_i[i];
                end else if (grant_oh[i]) begin
                    slot_valid[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bcast_en_o   <= 1'b0;
            bcast_data_o <= '0;
            bcast_rs_o   <= e_functional_unit'(FU_W'(0));
            rr_ptr       <= '0;
        end else if (flush_i) begin
            bcast_en_o   <= 1'b0;
            rr_ptr       <= '0;
        end else if (grant_vld) begin
            bcast_en_o   <= 1'b1;
            bcast_data_o <= slot_data[grant_idx];
            bcast_rs_o   <= e_functional_unit'(FU_W'(grant_idx));
            rr_ptr       <= next_ptr;
        end else begin
            bcast_en_o   <= 1'b0;
        end
    end

    always_comb begin : popcount
        pending_cnt_o = '0;
        for (int i = 0; i < N_SRC; i++) begin
            pending_cnt_o = pending_cnt_o + CNT_W'(slot_valid[i]);
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized and directed bench for cdb_arbiter against a slot/round-robin reference model.
module tb_cdb_arbiter;
    import types_pkg::*;

    localparam int N  = FU_CNT;
    localparam int DW = 64;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic [N-1:0]           result_valid_i = '0;
    logic [N-1:0][DW-1:0]   result_data_i = '0;
    logic [N-1:0]           result_ready_o;
    logic                   flush_i = 1'b0;
    logic                   bcast_en_o;
    logic [DW-1:0]          bcast_data_o;
    e_functional_unit       bcast_rs_o;
    logic [$clog2(N+1)-1:0] pending_cnt_o;

    cdb_arbiter #(.DATA_WIDTH(DW), .N_SRC(N)) dut (
        .clk            (clk),
        .rst            (rst),
        .result_valid_i (result_valid_i),
        .result_data_i  (result_data_i),
        .result_ready_o (result_ready_o),
        .flush_i        (flush_i),
        .bcast_en_o     (bcast_en_o),
        .bcast_data_o   (bcast_data_o),
        .bcast_rs_o     (bcast_rs_o),
        .pending_cnt_o  (pending_cnt_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: held results per source plus the round-robin start point.
    bit          m_held [N];
    logic [DW-1:0] m_data [N];
    int          m_rr;
    bit          m_en;
    logic [DW-1:0] m_bdata;
    int          m_rs;

    logic [N-1:0]         din;
    logic [N-1:0][DW-1:0] dval;
    logic [N-1:0]         obs_rdy;
    logic [N-1:0]         exp_rdy;

    function automatic int m_pending();
        int s = 0;
        for (int i = 0; i < N; i++) s += int'(m_held[i]);
        return s;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_held[i] = 1'b0;
            m_data[i] = '0;
        end
        m_rr = 0; m_en = 1'b0; m_bdata = '0; m_rs = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; result_valid_i = '0; flush_i = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Drives one cycle of inputs, records combinational ready, advances the model across the edge.
    task automatic step(input logic [N-1:0] v, input logic fl);
        int w;
        @(negedge clk);
        result_valid_i = v; flush_i = fl; result_data_i = dval;
        #1;
        obs_rdy = result_ready_o;
        w = -1;
        if (!fl) begin
            for (int k = 0; k < N; k++) begin
                if (w < 0 && m_held[(m_rr + k) % N]) w = (m_rr + k) % N;
            end
        end
        for (int i = 0; i < N; i++) exp_rdy[i] = !m_held[i] || (i == w) || fl;
        if (fl) begin
            for (int i = 0; i < N; i++) m_held[i] = 1'b0;
            m_en = 1'b0; m_rr = 0;
        end else begin
            if (w >= 0) begin
                m_en = 1'b1; m_bdata = m_data[w]; m_rs = w;
                m_held[w] = 1'b0; m_rr = (w + 1) % N;
            end else begin
                m_en = 1'b0;
            end
            for (int i = 0; i < N; i++) begin
                if (v[i] && exp_rdy[i]) begin
                    m_held[i] = 1'b1; m_data[i] = dval[i];
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        total += 5;
        if (bcast_en_o !== 1'b0) begin bad++; $display("FAIL reset_en got=%0b exp=0", bcast_en_o); end
        if (bcast_data_o !== '0) begin bad++; $display("FAIL reset_data got=%0h exp=0", bcast_data_o); end
        if (int'(bcast_rs_o) !== 0) begin bad++; $display("FAIL reset_rs got=%0d exp=0", bcast_rs_o); end
        if (int'(pending_cnt_o) !== 0) begin bad++; $display("FAIL reset_pending got=%0d exp=0", pending_cnt_o); end
        if (result_ready_o !== {N{1'b1}}) begin bad++; $display("FAIL reset_ready got=%b exp=%b", result_ready_o, {N{1'b1}}); end
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        dval = '0; dval[2] = 64'hDEAD;
        step(4'b0100, 1'b0);
        total += 2;
        if (bcast_en_o !== 1'b0) begin bad++; $display("FAIL single_bypass en got=%0b exp=0", bcast_en_o); end
        if (int'(pending_cnt_o) !== 1) begin bad++; $display("FAIL single_pending1 got=%0d exp=1", pending_cnt_o); end
        step(4'b0000, 1'b0);
        total += 3;
        if (bcast_en_o !== 1'b1) begin bad++; $display("FAIL single_en got=%0b exp=1", bcast_en_o); end
        if (bcast_data_o !== 64'hDEAD) begin bad++; $display("FAIL single_data got=%0h exp=dead", bcast_data_o); end
        if (int'(bcast_rs_o) !== 2) begin bad++; $display("FAIL single_rs got=%0d exp=2", bcast_rs_o); end
        step(4'b0000, 1'b0);
        total += 3;
        if (bcast_en_o !== 1'b0) begin bad++; $display("FAIL single_idle_en got=%0b exp=0", bcast_en_o); end
        if (int'(pending_cnt_o) !== 0) begin bad++; $display("FAIL single_pending0 got=%0d exp=0", pending_cnt_o); end
        if (bcast_data_o !== 64'hDEAD) begin bad++; $display("FAIL single_hold_data got=%0h exp=dead", bcast_data_o); end
    endtask

    task automatic test_all_at_once();
        logic [N-1:0][DW-1:0] saved;
        do_reset();
        for (int i = 0; i < N; i++) dval[i] = {$urandom, $urandom};
        saved = dval;
        step({N{1'b1}}, 1'b0);
        total += 1;
        if (int'(pending_cnt_o) !== N) begin bad++; $display("FAIL all_pending got=%0d exp=%0d", pending_cnt_o, N); end
        for (int k = 0; k < N; k++) begin
            step('0, 1'b0);
            total += 3;
            if (bcast_en_o !== 1'b1) begin bad++; $display("FAIL all_en[%0d] got=%0b exp=1", k, bcast_en_o); end
            if (int'(bcast_rs_o) !== k) begin bad++; $display("FAIL all_rs[%0d] got=%0d exp=%0d", k, bcast_rs_o, k); end
            if (bcast_data_o !== saved[k]) begin bad++; $display("FAIL all_data[%0d] got=%0h exp=%0h", k, bcast_data_o, saved[k]); end
        end
        step('0, 1'b0);
        total += 1;
        if (bcast_en_o !== 1'b0) begin bad++; $display("FAIL all_drain_en got=%0b exp=0", bcast_en_o); end
    endtask

    task automatic test_starvation();
        logic [N-1:0] vseq [6] = '{4'b0011, 4'b0001, 4'b0001, 4'b1001, 4'b0001, 4'b0001};
        int           rseq [6] = '{-1, 0, 1, 0, 3, 0};
        do_reset();
        for (int c = 0; c < 6; c++) begin
            for (int i = 0; i < N; i++) dval[i] = {$urandom, $urandom};
            step(vseq[c], 1'b0);
            total += 1;
            if (obs_rdy !== exp_rdy) begin bad++; $display("FAIL starve_ready[%0d] got=%b exp=%b", c, obs_rdy, exp_rdy); end
            if (rseq[c] >= 0) begin
                total += 3;
                if (bcast_en_o !== 1'b1) begin bad++; $display("FAIL starve_en[%0d] got=%0b exp=1", c, bcast_en_o); end
                if (int'(bcast_rs_o) !== rseq[c]) begin bad++; $display("FAIL starve_rs[%0d] got=%0d exp=%0d", c, bcast_rs_o, rseq[c]); end
                if (bcast_data_o !== m_bdata) begin bad++; $display("FAIL starve_data[%0d] got=%0h exp=%0h", c, bcast_data_o, m_bdata); end
            end
        end
    endtask

    task automatic test_wrap();
        int rseq [4] = '{-1, 2, 3, 0};
        logic [N-1:0] vseq [4] = '{4'b0100, 4'b1001, 4'b0000, 4'b0000};
        do_reset();
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < N; i++) dval[i] = {$urandom, $urandom};
            step(vseq[c], 1'b0);
            if (rseq[c] >= 0) begin
                total += 2;
                if (int'(bcast_rs_o) !== rseq[c] || bcast_en_o !== 1'b1) begin
                    bad++; $display("FAIL wrap_rs[%0d] got=%0d/en%0b exp=%0d/en1", c, bcast_rs_o, bcast_en_o, rseq[c]);
                end
                if (bcast_data_o !== m_bdata) begin bad++; $display("FAIL wrap_data[%0d] got=%0h exp=%0h", c, bcast_data_o, m_bdata); end
            end
        end
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < N; i++) dval[i] = {$urandom, $urandom};
        step(4'b1101, 1'b0);
        total += 1;
        if (int'(pending_cnt_o) !== 3) begin bad++; $display("FAIL flush_fill got=%0d exp=3", pending_cnt_o); end
        dval[1] = 64'hBAD0_BAD0_BAD0_BAD0;
        step(4'b0010, 1'b1);
        total += 3;
        if (obs_rdy !== {N{1'b1}}) begin bad++; $display("FAIL flush_ready got=%b exp=%b", obs_rdy, {N{1'b1}}); end
        if (bcast_en_o !== 1'b0) begin bad++; $display("FAIL flush_en got=%0b exp=0", bcast_en_o); end
        if (int'(pending_cnt_o) !== 0) begin bad++; $display("FAIL flush_pending got=%0d exp=0", pending_cnt_o); end
        for (int c = 0; c < 3; c++) begin
            step('0, 1'b0);
            total += 1;
            if (bcast_en_o !== 1'b0) begin bad++; $display("FAIL flush_leak[%0d] en=%0b rs=%0d exp en=0", c, bcast_en_o, bcast_rs_o); end
        end
    endtask

    task automatic test_async_reset();
        logic [DW-1:0] v1;
        do_reset();
        for (int i = 0; i < N; i++) dval[i] = {$urandom, $urandom};
        step({N{1'b1}}, 1'b0);
        step({N{1'b1}}, 1'b0);
        #2 rst = 1'b0;
        #1;
        total += 5;
        if (bcast_en_o !== 1'b0) begin bad++; $display("FAIL arst_en got=%0b exp=0", bcast_en_o); end
        if (bcast_data_o !== '0) begin bad++; $display("FAIL arst_data got=%0h exp=0", bcast_data_o); end
        if (int'(bcast_rs_o) !== 0) begin bad++; $display("FAIL arst_rs got=%0d exp=0", bcast_rs_o); end
        if (int'(pending_cnt_o) !== 0) begin bad++; $display("FAIL arst_pending got=%0d exp=0", pending_cnt_o); end
        if (result_ready_o !== {N{1'b1}}) begin bad++; $display("FAIL arst_ready got=%b exp=%b", result_ready_o, {N{1'b1}}); end
        model_reset();
        @(negedge clk);
        result_valid_i = '0;
        @(negedge clk);
        rst = 1'b1;
        v1 = {$urandom, $urandom};
        dval[1] = v1;
        step(4'b0010, 1'b0);
        step('0, 1'b0);
        total += 3;
        if (bcast_en_o !== 1'b1) begin bad++; $display("FAIL arst_after_en got=%0b exp=1", bcast_en_o); end
        if (int'(bcast_rs_o) !== 1) begin bad++; $display("FAIL arst_after_rs got=%0d exp=1", bcast_rs_o); end
        if (bcast_data_o !== v1) begin bad++; $display("FAIL arst_after_data got=%0h exp=%0h", bcast_data_o, v1); end
    endtask

    task automatic test_random();
        logic [N-1:0] v;
        logic         fl;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) dval[i] = {$urandom, $urandom};
            v  = N'($urandom);
            fl = ($urandom_range(0, 31) == 0);
            step(v, fl);
            total += 5;
            if (obs_rdy !== exp_rdy) begin bad++; $display("FAIL rnd_ready[%0d] got=%b exp=%b", c, obs_rdy, exp_rdy); end
            if (bcast_en_o !== m_en) begin bad++; $display("FAIL rnd_en[%0d] got=%0b exp=%0b", c, bcast_en_o, m_en); end
            if (bcast_data_o !== m_bdata) begin bad++; $display("FAIL rnd_data[%0d] got=%0h exp=%0h", c, bcast_data_o, m_bdata); end
            if (int'(bcast_rs_o) !== m_rs) begin bad++; $display("FAIL rnd_rs[%0d] got=%0d exp=%0d", c, bcast_rs_o, m_rs); end
            if (int'(pending_cnt_o) !== m_pending()) begin bad++; $display("FAIL rnd_pending[%0d] got=%0d exp=%0d", c, pending_cnt_o, m_pending()); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        dval = '0;
        model_reset();
        test_reset();
        test_single();
        test_all_at_once();
        test_starvation();
        test_wrap();
        test_flush();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
